// File: rtl/mccpu_ctrl.sv
// mccpu_ctrl: multi-cycle RISC-V control unit.
// Sequences one shared ALU, register file and memory port through
// FETCH/DECODE/EXEC/MEM/WB and stops in TRAP on an illegal instruction
// or a memory-ready timeout.
//
// Parameters: WAIT_TIMEOUT (max ready-wait cycles, 0 = no timeout),
//             TO_W (wait counter width, 2^TO_W > WAIT_TIMEOUT).
// Inputs : clk, rstn (async, active-low), Op/Funct7/Funct3 (latched IR),
//          Zero (branch condition true), imem_ready, dmem_ready.
// Outputs: imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite,
//          EXTOp, ALUOp, NPCOp, ALUSrc, WDSel, state, illegal, instr_done.
// Optional: define MCCPU_CTRL_PERF_EN to add cycle_cnt and instret_cnt.
//
// state  | meaning
// FETCH  | request instruction word, latch IR on imem_ready
// DECODE | classify opcode/funct, trap if unsupported
// EXEC   | ALU operation; branches retire here
// MEM    | data access; stores retire on dmem_ready
// WB     | register write and PC update
// TRAP   | sticky stop, only rstn leaves
module mccpu_ctrl #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int TO_W         = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [6:0] Op,
    input  logic [6:0] Funct7,
    input  logic [2:0] Funct3,
    input  logic       Zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [5:0] EXTOp,
    output logic [4:0] ALUOp,
    output logic [2:0] NPCOp,
    output logic       ALUSrc,
    output logic [1:0] WDSel,
    output logic [2:0] state,
    output logic       illegal,
    output logic       instr_done
`ifdef MCCPU_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [5:0] EXT_I = 6'b010000;
    localparam logic [5:0] EXT_S = 6'b001000;
    localparam logic [5:0] EXT_B = 6'b000100;
    localparam logic [5:0] EXT_U = 6'b000010;
    localparam logic [5:0] EXT_J = 6'b000001;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    state_t          cur;
    logic [TO_W-1:0] wait_cnt;
    logic            legal;
    logic            timeout_hit;

    wire is_ld   = (Op == OP_LD);
    wire is_st   = (Op == OP_ST);
    wire is_br   = (Op == OP_BR);
    wire is_jal  = (Op == OP_JAL);
    wire is_jalr = (Op == OP_JALR);

    always_comb begin
        legal  = 1'b0;
        ALUOp  = 5'b00011;
        EXTOp  = 6'b000000;
        ALUSrc = 1'b0;
        WDSel  = 2'b00;
        case (Op)
            OP_R: begin
                legal = 1'b1;
                case ({Funct7, Funct3})
                    {7'b0, 3'b000}:  ALUOp = 5'b00011;
                    {F7_ALT, 3'b000}: ALUOp = 5'b00100;
                    {7'b0, 3'b001}:  ALUOp = 5'b01111;
                    {7'b0, 3'b010}:  ALUOp = 5'b01010;
                    {7'b0, 3'b011}:  ALUOp = 5'b01011;
                    {7'b0, 3'b100}:  ALUOp = 5'b01100;
                    {7'b0, 3'b101}:  ALUOp = 5'b10000;
                    {F7_ALT, 3'b101}: ALUOp = 5'b10001;
                    {7'b0, 3'b110}:  ALUOp = 5'b01101;
                    {7'b0, 3'b111}:  ALUOp = 5'b01110;
                    default:         legal = 1'b0;
                endcase
            end
            OP_I: begin
                legal  = 1'b1;
                EXTOp  = EXT_I;
                ALUSrc = 1'b1;
                case (Funct3)
                    3'b000: ALUOp = 5'b00011;
                    3'b010: ALUOp = 5'b01010;
                    3'b011: ALUOp = 5'b01011;
                    3'b100: ALUOp = 5'b01100;
                    3'b110: ALUOp = 5'b01101;
                    3'b111: ALUOp = 5'b01110;
                    3'b001: begin
                        ALUOp = 5'b01111;
                        legal = (Funct7 == 7'b0);
                    end
                    default: begin
                        // funct3 101: upper immediate bits pick srli/srai
                        ALUOp = (Funct7 == F7_ALT) ? 5'b10001 : 5'b10000;
                        legal = (Funct7 == 7'b0) || (Funct7 == F7_ALT);
                    end
                endcase
            end
            OP_LD: begin
                legal  = (Funct3 == 3'b010);
                EXTOp  = EXT_I;
                ALUSrc = 1'b1;
                WDSel  = 2'b01;
            end
            OP_ST: begin
                legal  = (Funct3 == 3'b010);
                EXTOp  = EXT_S;
                ALUSrc = 1'b1;
            end
            OP_BR: begin
                legal = 1'b1;
                EXTOp = EXT_B;
                // Zero reports "condition true", so each funct3 selects its compare.
                // Reserved encodings fall back to the beq compare.
                case (Funct3)
                    3'b001:  ALUOp = 5'b00101;
                    3'b100:  ALUOp = 5'b00110;
                    3'b101:  ALUOp = 5'b00111;
                    3'b110:  ALUOp = 5'b01000;
                    3'b111:  ALUOp = 5'b01001;
                    default: ALUOp = 5'b00100;
                endcase
            end
            OP_JAL: begin
                legal = 1'b1;
                EXTOp = EXT_J;
                WDSel = 2'b10;
            end
            OP_JALR: begin
                legal  = 1'b1;
                EXTOp  = EXT_I;
                ALUSrc = 1'b1;
                WDSel  = 2'b10;
            end
            OP_LUI: begin
                legal  = 1'b1;
                EXTOp  = EXT_U;
                ALUSrc = 1'b1;
                ALUOp  = 5'b00001;
            end
            default: legal = 1'b0;
        endcase
    end

    // Fires on the last permitted wait cycle so the request is gone next cycle.
    assign timeout_hit = (WAIT_TIMEOUT != 0) &&
                         (32'(wait_cnt) == 32'(WAIT_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
            illegal  <= 1'b0;
        end else begin
            case (cur)
                S_FETCH: begin
                    if (imem_ready) begin
                        cur      <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        cur      <= S_TRAP;
                        wait_cnt <= '0;
                        illegal  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        cur <= S_EXEC;
                    end else begin
                        cur     <= S_TRAP;
                        illegal <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_br)                cur <= S_FETCH;
                    else if (is_ld || is_st)  cur <= S_MEM;
                    else                      cur <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        cur      <= is_st ? S_FETCH : S_WB;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        cur      <= S_TRAP;
                        wait_cnt <= '0;
                        illegal  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB:    cur <= S_FETCH;
                S_TRAP:  cur <= S_TRAP;
                default: begin
                    cur     <= S_TRAP;
                    illegal <= 1'b1;
                end
            endcase
        end
    end

    // Strobes are gated by rstn so an in-flight request drops with reset.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        instr_done = 1'b0;
        NPCOp      = 3'b000;
        if (rstn) begin
            case (cur)
                S_FETCH: begin
                    imem_req = 1'b1;
                    IRWrite  = imem_ready;
                end
                S_EXEC: begin
                    if (is_br) begin
                        PCWrite    = 1'b1;
                        NPCOp      = {2'b00, Zero};
                        instr_done = 1'b1;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    MemWrite = is_st;
                    if (dmem_ready && is_st) begin
                        PCWrite    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                    if (is_jal)       NPCOp = 3'b010;
                    else if (is_jalr) NPCOp = 3'b100;
                end
                default: ;
            endcase
        end
    end

    assign state = cur;

`ifdef MCCPU_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule
